sdf_bitrev_reorder: RTL and testbench
=====================================

Name: sdf_bitrev_reorder

Overview:
Downstream neighbour of sdf_top. It consumes the bit-reversed-order NTT output stream (one coefficient per valid cycle, N = 2**addr_width points per frame). It re-emits each frame in natural order through a valid/ready output. The block is a ping-pong double buffer: the write side scatters samples to bit-reversed addresses, and the read side drains the other bank sequentially.

Parameters:
data_width, 64, width of one coefficient word (same as sdf_top).
addr_width, 4, log2 of frame length N; N = 2**addr_width.

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
in_valid  input  1  in_data holds a valid sdf_out sample this cycle.
in_data  input  data_width  coefficient from sdf_top, bit-reversed order.
in_ready  output  1  a bank is free to accept the sample; informational only, because sdf_top cannot stall.
out_valid  output  1  out_data holds a valid natural-order coefficient.
out_ready  input  1  downstream accepts out_data this cycle.
out_data  output  data_width  natural-order coefficient.
out_last  output  1  marks coefficient N-1 of a frame; qualified by out_valid.
frame_done_tick  output  1  one-cycle pulse on the handshake of the out_last word.
overflow  output  1  sticky error flag; set when a sample is dropped.

Behaviour:
- Reset (async, rst_n=0). Every output goes low: out_valid, out_last, frame_done_tick, overflow, out_data=0, in_ready=1. wbank=0, rbank=0, wcnt=0, rcnt=0, full[1:0]=0. Memory contents are not reset.
- Storage: two banks of N words each, implemented as reg arrays with combinational read.
- Write side:
  - A write fires when in_valid && !full[wbank].
  - The sample goes to mem[wbank][bitrev(wcnt)], where bitrev reverses the addr_width bits. wcnt increments modulo N.
  - When wcnt==N-1 on a write: set full[wbank], toggle wbank, and wrap wcnt to 0.
- in_ready = !full[wbank].
- Drop rule: in_valid && full[wbank] means the sample is discarded. overflow is set and stays set until reset. wcnt does not advance.
- Read side: the output register loads when (!out_valid || out_ready) && full[rbank].
  - Loaded values: out_data <= mem[rbank][rcnt], out_valid <= 1, out_last <= (rcnt==N-1).
  - rcnt increments modulo N.
  - On loading rcnt==N-1: clear full[rbank] and toggle rbank.
- If no load occurs and out_ready && out_valid, then out_valid and out_last go to 0.
- Handshake: out_data, out_valid and out_last stay stable while out_valid && !out_ready.
- frame_done_tick = 1 for exactly the cycle after the edge on which out_valid && out_ready && out_last.
- Latency: the first word of a frame becomes out_valid on the edge after the edge that writes sample N-1, i.e. 1 cycle later. With out_ready held at 1, the output is a continuous N-cycle burst.
- Simultaneous events:
  - Setting full on one bank while clearing full on the other bank, in the same cycle, is legal; both updates take effect.
  - A write to the bank currently being read is impossible, because full[rbank] blocks it.
  - A frame write may start on the same edge that the read side frees the bank; that write sees full already cleared only on the next edge. No combinational bypass.
- Throughput: with out_ready=1, sustained input of one sample per cycle never overflows.
- Mid-frame reset: everything returns to reset state. Partial frames are discarded, and the next in_valid is treated as sample 0 of a new frame.
- No arithmetic and no modular reduction; data passes through unchanged.

Decomposition:
- The shared NTT package holds:
  - the default data_width and addr_width;
  - a bitrev function parameterised on addr_width, which the sdf twiddle ROM address logic also reuses.
- One sub-module is natural: sdf_pingpong_ram, two banks with one write port and one combinational read port, bank-select inputs. Everything else stays in sdf_bitrev_reorder.

Test Plan:
1. N=16, in_data=k on consecutive cycles k=0..15, out_ready=1 -> output order 0,8,4,12,2,10,6,14,1,9,5,13,3,11,7,15. First out_valid 1 cycle after the 16th write. out_last with value 15. One frame_done_tick follows.
2. Three back-to-back frames (frame f data = 16f+k), out_ready=1 -> 48 continuous outputs, each frame permuted as in test 1. in_ready stays 1 and overflow=0.
3. Frame 1 streamed, out_ready=0 throughout, then frame 2 streamed and frame 3 begins -> in_ready=0 from the first sample of frame 3. overflow=1 and those samples are dropped. Raising out_ready then delivers frames 1 and 2 intact.
4. out_ready toggled 1,0,1,0 during drain -> out_data is held stable whenever out_ready=0. No word is lost or duplicated; the order still matches test 1.
5. rst_n pulsed low for 2 ns after 7 samples -> all outputs 0 immediately, with no clock needed. The next 16 samples (values 100+k) produce the test 1 permutation offset by 100.
6. in_valid gapped (samples on every other cycle) -> identical output order. out_valid asserts 1 cycle after the last write.

Source files
------------

// File: rtl/sdf_bitrev_reorder_pkg.sv
// Shared NTT package: default datapath sizes and the bit-reverse helper.
// Used by the reorder buffer and reused by the sdf twiddle ROM addressing.
package sdf_bitrev_reorder_pkg;

    localparam int DATA_WIDTH = 64;
    localparam int ADDR_WIDTH = 4;

    // Reverse the low w bits of a (w <= 32). The full 32-bit word is
    // mirrored, then shifted down so the w-bit field lands at bit 0.
    function automatic logic [31:0] bitrev(input logic [31:0] a,
                                           input int          w);
        logic [31:0] r;
        r = {<<{a}};
        return r >> (32 - w);
    endfunction

endpackage

// File: rtl/sdf_bitrev_reorder_pingpong_ram.sv
// sdf_pingpong_ram: two banks of 2**addr_width words, one write port and
// one combinational read port, each with its own bank select.
//   clk      : write clock
//   we_i     : write enable; wbank_i/waddr_i/wdata_i address and data
//   rbank_i  : read bank;  raddr_i read address; rdata_o read data
import sdf_bitrev_reorder_pkg::*;

module sdf_pingpong_ram #(
    parameter int data_width = DATA_WIDTH,
    parameter int addr_width = ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  we_i,
    input  logic                  wbank_i,
    input  logic [addr_width-1:0] waddr_i,
    input  logic [data_width-1:0] wdata_i,
    input  logic                  rbank_i,
    input  logic [addr_width-1:0] raddr_i,
    output logic [data_width-1:0] rdata_o
);

    localparam int N = 1 << addr_width;

    logic [data_width-1:0] mem_q [2][N];

    // Storage is deliberately not reset.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[wbank_i][waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[rbank_i][raddr_i];

endmodule

// File: rtl/sdf_bitrev_reorder.sv
// Ping-pong reorder buffer: bit-reversed NTT frames in, natural order out.
// Ports:
//   clk, rst_n              : clock, async active-low reset
//   in_valid, in_data       : bit-reversed input stream (cannot stall)
//   in_ready                : current write bank free (informational)
//   out_valid/ready/data    : natural-order valid/ready output
//   out_last                : word N-1 of a frame
//   frame_done_tick         : pulse after the out_last handshake
//   overflow                : sticky, set when a sample is dropped
import sdf_bitrev_reorder_pkg::*;

module sdf_bitrev_reorder #(
    parameter int data_width = DATA_WIDTH,
    parameter int addr_width = ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    input  logic [data_width-1:0] in_data,
    output logic                  in_ready,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [data_width-1:0] out_data,
    output logic                  out_last,
    output logic                  frame_done_tick,
    output logic                  overflow
);

    localparam logic [addr_width-1:0] LAST = '1;

    logic [1:0]            full_q, full_d;
    logic                  wbank_q, wbank_d;
    logic                  rbank_q, rbank_d;
    logic [addr_width-1:0] wcnt_q, wcnt_d;
    logic [addr_width-1:0] rcnt_q, rcnt_d;
    logic                  ov_q, ov_d;
    logic                  ol_q, ol_d;
    logic [data_width-1:0] od_q, od_d;
    logic                  tick_q, tick_d;
    logic                  ovf_q, ovf_d;

    logic                  wr_fire, wr_end, rd_load, rd_end;
    logic [addr_width-1:0] waddr;
    logic [data_width-1:0] rdata;

    assign wr_fire = in_valid && !full_q[wbank_q];
    assign wr_end  = wr_fire && (wcnt_q == LAST);
    assign rd_load = (!ov_q || out_ready) && full_q[rbank_q];
    assign rd_end  = rd_load && (rcnt_q == LAST);
    assign waddr   = addr_width'(bitrev(32'(wcnt_q), addr_width));

    sdf_pingpong_ram #(
        .data_width (data_width),
        .addr_width (addr_width)
    ) u_ram (
        .clk     (clk),
        .we_i    (wr_fire),
        .wbank_i (wbank_q),
        .waddr_i (waddr),
        .wdata_i (in_data),
        .rbank_i (rbank_q),
        .raddr_i (rcnt_q),
        .rdata_o (rdata)
    );

    always_comb begin
        // Fill and drain always target different banks, so both
        // updates can land in the same cycle.
        full_d = full_q;
        if (rd_end) full_d[rbank_q] = 1'b0;
        if (wr_end) full_d[wbank_q] = 1'b1;

        wcnt_d  = wr_fire ? wcnt_q + 1'b1 : wcnt_q;
        wbank_d = wbank_q ^ wr_end;
        rcnt_d  = rd_load ? rcnt_q + 1'b1 : rcnt_q;
        rbank_d = rbank_q ^ rd_end;

        ov_d = ov_q;
        ol_d = ol_q;
        od_d = od_q;
        if (rd_load) begin
            ov_d = 1'b1;
            ol_d = (rcnt_q == LAST);
            od_d = rdata;
        end else if (out_ready && ov_q) begin
            ov_d = 1'b0;
            ol_d = 1'b0;
        end

        tick_d = ov_q && out_ready && ol_q;
        ovf_d  = ovf_q || (in_valid && full_q[wbank_q]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full_q  <= '0;
            wbank_q <= 1'b0;
            rbank_q <= 1'b0;
            wcnt_q  <= '0;
            rcnt_q  <= '0;
            ov_q    <= 1'b0;
            ol_q    <= 1'b0;
            od_q    <= '0;
            tick_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            full_q  <= full_d;
            wbank_q <= wbank_d;
            rbank_q <= rbank_d;
            wcnt_q  <= wcnt_d;
            rcnt_q  <= rcnt_d;
            ov_q    <= ov_d;
            ol_q    <= ol_d;
            od_q    <= od_d;
            tick_q  <= tick_d;
            ovf_q   <= ovf_d;
        end
    end

    assign in_ready        = !full_q[wbank_q];
    assign out_valid       = ov_q;
    assign out_last        = ol_q;
    assign out_data        = od_q;
    assign frame_done_tick = tick_q;
    assign overflow        = ovf_q;

endmodule

// File: tb/tb_sdf_bitrev_reorder.sv
// Directed bench for sdf_bitrev_reorder: table of single-frame cases plus
// hand-written back-to-back, overflow and mid-frame reset sequences.
module tb_sdf_bitrev_reorder;

    localparam int DW = 64;
    localparam int AW = 4;
    localparam int N  = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic          in_ready;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [DW-1:0] out_data;
    logic          out_last;
    logic          frame_done_tick;
    logic          overflow;

    sdf_bitrev_reorder #(.data_width(DW), .addr_width(AW)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .in_valid        (in_valid),
        .in_data         (in_data),
        .in_ready        (in_ready),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_data        (out_data),
        .out_last        (out_last),
        .frame_done_tick (frame_done_tick),
        .overflow        (overflow)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Hand-computed natural-order position j holds input sample perm[j].
    int perm [N] = '{0, 8, 4, 12, 2, 10, 6, 14, 1, 9, 5, 13, 3, 11, 7, 15};

    // Output monitor, sampled on the falling edge.
    logic [DW-1:0] got_d [$];
    bit            got_l [$];
    int            got_c [$];
    int            rise_q [$];
    int            tick_q [$];
    int            hold_n = 0;
    int            hold_bad = 0;
    int            drop_n = 0;
    bit            pv = 0, pr = 0, pl = 0;
    logic [DW-1:0] pd = '0;

    initial forever begin
        @(negedge clk or negedge rst_n);
        if (!rst_n) begin
            pv = 0;
        end else begin
            if (pv && !pr) begin
                hold_n++;
                if (!(out_valid && out_data == pd && out_last == pl))
                    hold_bad++;
            end
            if (out_valid && !pv) rise_q.push_back(cyc);
            if (out_valid && out_ready) begin
                got_d.push_back(out_data);
                got_l.push_back(out_last);
                got_c.push_back(cyc);
            end
            if (frame_done_tick) tick_q.push_back(cyc);
            if (in_valid && !in_ready) drop_n++;
            pv = out_valid;
            pr = out_ready;
            pd = out_data;
            pl = out_last;
        end
    end

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        #1;
        chk("reset_ctl",
            {59'd0, out_valid, out_last, frame_done_tick, overflow, in_ready},
            64'b00001);
        chk("reset_data", out_data, 64'd0);
        step(1);
        rst_n = 1'b1;
        step(1);
    endtask

    task automatic send(input int base, input int n, input bit gap);
        for (int k = 0; k < n; k++) begin
            in_valid = 1'b1;
            in_data  = 64'(base + k);
            step(1);
            if (gap && k != n - 1) begin
                in_valid = 1'b0;
                step(1);
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_words(input int target, input int budget);
        for (int i = 0; i < budget && got_d.size() < target; i++) step(1);
    endtask

    task automatic check_frame(input string nm, input int idx, input int base);
        for (int j = 0; j < N; j++) begin
            if (idx + j < got_d.size()) begin
                chk({nm, "_data"}, got_d[idx+j], 64'(base + perm[j]));
                chk({nm, "_last"}, 64'(got_l[idx+j]), 64'(j == N - 1));
            end
        end
    endtask

    typedef struct {
        string name;
        int    base;
        bit    gap;
        bit    toggle;
        int    exp_first;
        int    exp_last;
    } case_t;

    case_t cases [3];

    initial begin
        int m, r0, t0, lw, d0;

        cases[0] = '{"inorder", 0,  1'b0, 1'b0, 0,  15};
        cases[1] = '{"gapped",  32, 1'b1, 1'b0, 32, 47};
        cases[2] = '{"toggle",  64, 1'b0, 1'b1, 64, 79};

        step(1);

        for (int c = 0; c < 3; c++) begin
            do_reset();
            out_ready = cases[c].toggle ? 1'b0 : 1'b1;
            m  = got_d.size();
            r0 = rise_q.size();
            t0 = tick_q.size();
            send(cases[c].base, N, cases[c].gap);
            lw = cyc;
            if (cases[c].toggle) begin
                for (int i = 0; i < 80 && got_d.size() < m + N; i++) begin
                    out_ready = ~out_ready;
                    step(1);
                end
            end else begin
                wait_words(m + N, 60);
            end
            out_ready = 1'b1;
            step(4);
            chk({cases[c].name, "_words"}, 64'(got_d.size() - m), 64'(N));
            if (got_d.size() >= m + N) begin
                chk({cases[c].name, "_first"}, got_d[m],
                    64'(cases[c].exp_first));
                chk({cases[c].name, "_lastval"}, got_d[m+N-1],
                    64'(cases[c].exp_last));
                if (!cases[c].toggle)
                    chk({cases[c].name, "_burst"},
                        64'(got_c[m+N-1] - got_c[m]), 64'(N - 1));
                if (tick_q.size() > t0)
                    chk({cases[c].name, "_tick_cyc"}, 64'(tick_q[t0]),
                        64'(got_c[m+N-1] + 1));
            end
            check_frame(cases[c].name, m, cases[c].base);
            chk({cases[c].name, "_rise"},
                64'(rise_q.size() > r0 ? rise_q[r0] : -1), 64'(lw + 1));
            chk({cases[c].name, "_ticks"}, 64'(tick_q.size() - t0), 64'd1);
            chk({cases[c].name, "_ovf"}, 64'(overflow), 64'd0);
        end
        chk("hold_seen", 64'(hold_n > 0), 64'd1);

        // Three back-to-back frames with a free-running sink.
        do_reset();
        out_ready = 1'b1;
        m  = got_d.size();
        t0 = tick_q.size();
        d0 = drop_n;
        send(0, N, 1'b0);
        send(16, N, 1'b0);
        send(32, N, 1'b0);
        wait_words(m + 3 * N, 80);
        step(4);
        chk("b2b_words", 64'(got_d.size() - m), 64'(3 * N));
        check_frame("b2b_f0", m, 0);
        check_frame("b2b_f1", m + N, 16);
        check_frame("b2b_f2", m + 2 * N, 32);
        if (got_d.size() >= m + 3 * N)
            chk("b2b_burst", 64'(got_c[m+3*N-1] - got_c[m]), 64'(3 * N - 1));
        chk("b2b_drops", 64'(drop_n - d0), 64'd0);
        chk("b2b_ovf", 64'(overflow), 64'd0);
        chk("b2b_ticks", 64'(tick_q.size() - t0), 64'd3);

        // Stalled sink: both banks fill, third frame is dropped.
        do_reset();
        out_ready = 1'b0;
        m  = got_d.size();
        d0 = drop_n;
        send(0, N, 1'b0);
        chk("ovr_rdy_mid", 64'(in_ready), 64'd1);
        send(16, N, 1'b0);
        chk("ovr_rdy_full", 64'(in_ready), 64'd0);
        chk("ovr_ovf_pre", 64'(overflow), 64'd0);
        send(32, 4, 1'b0);
        chk("ovr_ovf", 64'(overflow), 64'd1);
        chk("ovr_drops", 64'(drop_n - d0), 64'd4);
        out_ready = 1'b1;
        wait_words(m + 2 * N, 80);
        step(6);
        chk("ovr_words", 64'(got_d.size() - m), 64'(2 * N));
        check_frame("ovr_f0", m, 0);
        check_frame("ovr_f1", m + N, 16);
        chk("ovr_sticky", 64'(overflow), 64'd1);

        // Async reset mid-frame while the output is holding a word.
        do_reset();
        out_ready = 1'b0;
        send(50, N, 1'b0);
        send(200, 7, 1'b0);
        chk("rst_pre_valid", 64'(out_valid), 64'd1);
        chk("rst_pre_data", out_data, 64'd50);
        #1;
        rst_n = 1'b0;
        #1;
        chk("rst_async_ctl",
            {59'd0, out_valid, out_last, frame_done_tick, overflow, in_ready},
            64'b00001);
        chk("rst_async_data", out_data, 64'd0);
        #1;
        rst_n = 1'b1;
        step(1);
        out_ready = 1'b1;
        m  = got_d.size();
        r0 = rise_q.size();
        send(100, N, 1'b0);
        lw = cyc;
        wait_words(m + N, 60);
        step(6);
        chk("rst_words", 64'(got_d.size() - m), 64'(N));
        check_frame("rst_f", m, 100);
        chk("rst_rise",
            64'(rise_q.size() > r0 ? rise_q[r0] : -1), 64'(lw + 1));

        chk("hold_stable", 64'(hold_bad), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
